// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined multiplexer tree.
package mux_pkg;

  localparam int MUX_WIDTH_DEF = 3;
  localparam int MUX_N_DEF     = 8;

  // Ceiling log2 usable in constant expressions on flows without $clog2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Low bit of channel idx inside a flattened bus of width-bit channels.
  function automatic int chan_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mux_2_1.sv
// Plain 2:1 multiplexer; sel = 0 picks a (the even channel).
module mux_2_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_tree_stage.sv
// One registered level of the mux tree: N_IN channels in, N_IN/2 out.
// The stage consumes select bit 0 and forwards the remaining select bits.
module mux_tree_stage
  import mux_pkg::*;
#(
  parameter int  WIDTH     = MUX_WIDTH_DEF,
  parameter int  N_IN      = MUX_N_DEF,
  localparam int SEL_IN    = clog2(N_IN),
  localparam int SEL_OUT_W = (SEL_IN > 1) ? SEL_IN - 1 : 1,
  localparam int N_OUT     = N_IN / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   ready,
  input  logic [N_IN*WIDTH-1:0]  d,
  input  logic [SEL_IN-1:0]      s,
  input  logic                   down_ready,
  output logic                   out_valid,
  output logic [N_OUT*WIDTH-1:0] q,
  output logic [SEL_OUT_W-1:0]   s_rem
);

  logic [N_OUT*WIDTH-1:0] mux_y;
  logic                   v;
  logic                   load;

  for (genvar j = 0; j < N_OUT; j++) begin : g_mux
    mux_2_1 #(.WIDTH(WIDTH)) u_mux (
      .a  (d[chan_lo(2*j, WIDTH) +: WIDTH]),
      .b  (d[chan_lo(2*j+1, WIDTH) +: WIDTH]),
      .sel(s[0]),
      .y  (mux_y[chan_lo(j, WIDTH) +: WIDTH])
    );
  end

  // An empty stage loads regardless of downstream, so bubbles collapse.
  // Held low in reset so upstream never sees a transfer it would lose.
  assign load      = !rst && (!v || down_ready);
  assign ready     = load;
  assign out_valid = v;

  // Data and valid register; data may load garbage while the valid bit stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      q <= '0;
    end else if (load) begin
      v <= in_valid;
      q <= mux_y;
    end
  end

  if (SEL_IN > 1) begin : g_sel
    // Carry the select bits that later levels still need.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_rem <= '0;
      end else if (load) begin
        s_rem <= s[SEL_IN-1:1];
      end
    end
  end else begin : g_nosel
    assign s_rem = '0;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree, one register stage per tree level.
//
// Handshake: a beat moves in when in_valid && in_ready and out when
// out_valid && out_ready. in_ready depends only on stage valid bits, rst
// and out_ready (never on in_valid, s or d). While out_valid && !out_ready,
// y and out_valid hold. The source must hold s and d while in_valid is
// high and in_ready is low.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int  WIDTH = MUX_WIDTH_DEF,
  parameter int  N     = MUX_N_DEF,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   s,
  input  logic [N*WIDTH-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y
);

  // Index k is the boundary in front of stage k; index SEL_W is the consumer.
  logic [SEL_W:0] valid_chain;
  logic [SEL_W:0] ready_chain;

  assign valid_chain[0]     = in_valid;
  assign in_ready           = ready_chain[0];
  assign ready_chain[SEL_W] = out_ready;
  assign out_valid          = valid_chain[SEL_W];

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int N_IN      = N >> k;
    localparam int SEL_IN    = SEL_W - k;
    localparam int SEL_OUT_W = (SEL_IN > 1) ? SEL_IN - 1 : 1;

    logic [N_IN*WIDTH-1:0]     d_in;
    logic [SEL_IN-1:0]         s_in;
    logic [N_IN/2*WIDTH-1:0]   q;
    logic [SEL_OUT_W-1:0]      s_rem;

    if (k == 0) begin : g_first
      assign d_in = d;
      assign s_in = s;
    end else begin : g_next
      assign d_in = g_lvl[k-1].q;
      assign s_in = g_lvl[k-1].s_rem;
    end

    mux_tree_stage #(.WIDTH(WIDTH), .N_IN(N_IN)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid_chain[k]),
      .ready     (ready_chain[k]),
      .d         (d_in),
      .s         (s_in),
      .down_ready(ready_chain[k+1]),
      .out_valid (valid_chain[k+1]),
      .q         (q),
      .s_rem     (s_rem)
    );

    if (k == SEL_W - 1) begin : g_last
      // The final level has no select bits left to forward.
      logic [SEL_OUT_W-1:0] sel_unused;
      assign sel_unused = s_rem;
      assign y          = q;
    end
  end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: N=8/WIDTH=3 directed tests plus N=2/WIDTH=1 and
// N=32/WIDTH=16 random streams, all checked against expected queues.
module tb_mux_tree_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_count;
  int fail_count;

  // ---------------- DUT N=8, WIDTH=3 ----------------
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2:0]  s8, y8;
  logic [23:0] d8;

  mux_tree_pipe #(.WIDTH(3), .N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .s(s8), .d(d8), .out_valid(out_valid8), .out_ready(out_ready8), .y(y8)
  );

  // ---------------- DUT N=2, WIDTH=1 ----------------
  logic       in_valid2, in_ready2, out_valid2, out_ready2;
  logic [0:0] s2, y2;
  logic [1:0] d2;

  mux_tree_pipe #(.WIDTH(1), .N(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .s(s2), .d(d2), .out_valid(out_valid2), .out_ready(out_ready2), .y(y2)
  );

  // ---------------- DUT N=32, WIDTH=16 ----------------
  logic         in_valid32, in_ready32, out_valid32, out_ready32;
  logic [4:0]   s32;
  logic [15:0]  y32;
  logic [511:0] d32;

  mux_tree_pipe #(.WIDTH(16), .N(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .s(s32), .d(d32), .out_valid(out_valid32), .out_ready(out_ready32), .y(y32)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards ----------------
  logic [2:0]  exp8_q[$];
  logic [0:0]  exp2_q[$];
  logic [15:0] exp32_q[$];
  logic [2:0]  e8;
  logic [0:0]  e2;
  logic [15:0] e32;
  logic        took2, took32;
  int          pop2, pop32;

  always @(negedge clk) begin
    if (rst) begin
      exp8_q.delete();
    end else begin
      if (in_valid8 && in_ready8) exp8_q.push_back(d8[int'(s8)*3 +: 3]);
      if (out_valid8 && out_ready8) begin
        if (exp8_q.size() == 0) begin
          cmp_count++;
          fail_count++;
          $display("FAIL sb8_unexpected: got y=%0d, expected no output", y8);
        end else begin
          e8 = exp8_q.pop_front();
          chk("sb8_y", 32'(y8), 32'(e8));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp2_q.delete();
    end else begin
      if (in_valid2 && in_ready2) begin
        exp2_q.push_back(d2[s2]);
        took2 = 1'b1;
      end
      if (out_valid2 && out_ready2) begin
        pop2++;
        if (exp2_q.size() == 0) begin
          cmp_count++;
          fail_count++;
          $display("FAIL sb2_unexpected: got y=%0d, expected no output", y2);
        end else begin
          e2 = exp2_q.pop_front();
          chk("sb2_y", 32'(y2), 32'(e2));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp32_q.delete();
    end else begin
      if (in_valid32 && in_ready32) begin
        exp32_q.push_back(d32[int'(s32)*16 +: 16]);
        took32 = 1'b1;
      end
      if (out_valid32 && out_ready32) begin
        pop32++;
        if (exp32_q.size() == 0) begin
          cmp_count++;
          fail_count++;
          $display("FAIL sb32_unexpected: got y=%0d, expected no output", y32);
        end else begin
          e32 = exp32_q.pop_front();
          chk("sb32_y", 32'(y32), 32'(e32));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [23:0] d;
    logic [2:0]  s;
    logic [2:0]  exp;
  } vec_t;

  vec_t tbl[12];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    fail_count++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    cmp_count = 0;
    fail_count = 0;
    pop2 = 0;
    pop32 = 0;
    took2 = 1'b0;
    took32 = 1'b0;
    rst = 1'b1;
    in_valid8 = 1'b0; s8 = '0; d8 = '0; out_ready8 = 1'b0;
    in_valid2 = 1'b0; s2 = '0; d2 = '0; out_ready2 = 1'b0;
    in_valid32 = 1'b0; s32 = '0; d32 = '0; out_ready32 = 1'b0;

    // Channel i carries i; second pattern puts 6,4,2,0,7,5,3,1 on channels 0..7.
    for (int i = 0; i < 8; i++) begin
      tbl[i].d = 24'o76543210;
      tbl[i].s = 3'(i);
      tbl[i].exp = 3'(i);
    end
    tbl[8]  = '{d: 24'o13570246, s: 3'd0, exp: 3'd6};
    tbl[9]  = '{d: 24'o13570246, s: 3'd7, exp: 3'd1};
    tbl[10] = '{d: 24'o13570246, s: 3'd4, exp: 3'd7};
    tbl[11] = '{d: 24'o13570246, s: 3'd3, exp: 3'd0};

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", 32'(out_valid8), 0);
      chk("rst_y", 32'(y8), 0);
      chk("rst_in_ready", 32'(in_ready8), 0);
      chk("rst_in_ready32", 32'(in_ready32), 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready8), 1);

    // Table sweep, back-to-back, output never stalled; latency 3.
    out_ready8 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        in_valid8 = 1'b1;
        s8 = tbl[i].s;
        d8 = tbl[i].d;
      end else begin
        in_valid8 = 1'b0;
      end
      step();
      if (i >= 2) begin
        chk("sweep_out_valid", 32'(out_valid8), 1);
        chk("sweep_y", 32'(y8), 32'(tbl[i-2].exp));
      end else begin
        chk("sweep_latency_ov", 32'(out_valid8), 0);
      end
    end
    step();
    chk("sweep_idle", 32'(out_valid8), 0);

    // Backpressure: s = 5,2,7,1 with out_ready low for six edges.
    out_ready8 = 1'b0;
    d8 = 24'o76543210;
    in_valid8 = 1'b1; s8 = 3'd5; step();
    chk("bp_ov_1", 32'(out_valid8), 0);
    s8 = 3'd2; step();
    chk("bp_ov_2", 32'(out_valid8), 0);
    s8 = 3'd7; step();
    chk("bp_ov_3", 32'(out_valid8), 1);
    chk("bp_y_first", 32'(y8), 5);
    s8 = 3'd1;
    #1;
    chk("bp_full_in_ready", 32'(in_ready8), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ov", 32'(out_valid8), 1);
      chk("bp_hold_y", 32'(y8), 5);
      chk("bp_hold_in_ready", 32'(in_ready8), 0);
    end
    out_ready8 = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready8), 1);
    step();
    in_valid8 = 1'b0;
    chk("bp_y_2", 32'(y8), 2);
    step();
    chk("bp_y_7", 32'(y8), 7);
    step();
    chk("bp_y_1", 32'(y8), 1);
    step();
    chk("bp_drained", 32'(out_valid8), 0);
    chk("bp_queue_empty", 32'(exp8_q.size()), 0);

    // Bubble collapse: second beat enters while the output is stalled.
    out_ready8 = 1'b0;
    in_valid8 = 1'b1; s8 = 3'd3; step();
    in_valid8 = 1'b0; step(); step();
    chk("bub_first_y", 32'(y8), 3);
    in_valid8 = 1'b1; s8 = 3'd6;
    #1;
    chk("bub_ready_stalled", 32'(in_ready8), 1);
    step();
    in_valid8 = 1'b0; step(); step();
    chk("bub_still_held", 32'(y8), 3);
    out_ready8 = 1'b1;
    step();
    chk("bub_adjacent_ov", 32'(out_valid8), 1);
    chk("bub_adjacent_y", 32'(y8), 6);
    step();
    chk("bub_drained", 32'(out_valid8), 0);

    // Reset with three beats in flight.
    in_valid8 = 1'b1; s8 = 3'd1; step();
    s8 = 3'd4; step();
    s8 = 3'd6; step();
    in_valid8 = 1'b0;
    chk("rmid_prefill_y", 32'(y8), 1);
    rst = 1'b1;
    step();
    chk("rmid_ov", 32'(out_valid8), 0);
    chk("rmid_y", 32'(y8), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rmid_no_stale", 32'(out_valid8), 0);
    end
    in_valid8 = 1'b1; s8 = 3'd2; step();
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 10) begin
      step();
      n++;
    end
    chk("rmid_fresh_latency", n, 2);
    chk("rmid_fresh_y", 32'(y8), 2);
    step();

    // Latency of the degenerate and the wide configurations.
    out_ready2 = 1'b1;
    in_valid2 = 1'b1; s2 = 1'b1; d2 = 2'b10; step();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      step();
      n++;
    end
    chk("lat2", n, 0);
    chk("lat2_y", 32'(y2), 1);
    step();

    out_ready32 = 1'b1;
    for (int k = 0; k < 16; k++) d32[k*32 +: 32] = $urandom();
    in_valid32 = 1'b1; s32 = 5'd17; step();
    in_valid32 = 1'b0;
    n = 0;
    while (!out_valid32 && n < 20) begin
      step();
      n++;
    end
    chk("lat32", n, 4);
    step();

    // Random streams with random backpressure on both configurations.
    took2 = 1'b0;
    took32 = 1'b0;
    fork
      begin
        for (int c = 0; c < 300; c++) begin
          if (!in_valid2 || took2) begin
            in_valid2 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            d2 = 2'($urandom_range(0, 3));
          end
          took2 = 1'b0;
          out_ready2 = ($urandom_range(0, 3) != 0);
          step();
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
      end
      begin
        for (int c = 0; c < 300; c++) begin
          if (!in_valid32 || took32) begin
            in_valid32 = 1'($urandom_range(0, 1));
            s32 = 5'($urandom_range(0, 31));
            for (int k = 0; k < 16; k++) d32[k*32 +: 32] = $urandom();
          end
          took32 = 1'b0;
          out_ready32 = ($urandom_range(0, 3) != 0);
          step();
        end
        in_valid32 = 1'b0;
        out_ready32 = 1'b1;
      end
    join
    repeat (10) step();
    chk("rand2_queue_empty", 32'(exp2_q.size()), 0);
    chk("rand32_queue_empty", 32'(exp32_q.size()), 0);
    chk("rand2_activity", 32'(pop2 > 50), 1);
    chk("rand32_activity", 32'(pop32 > 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree with a valid/ready handshake. It is the general successor to the fixed 8:1 tree of 2:1 muxes. Each tree level is a registered stage, so wide or deep selectors close timing. The block sits between multi-source datapaths and a single consumer that can apply backpressure.

## Interface
Parameters:
- WIDTH, 3, bit width of each data channel
- N, 8, number of input channels; power of two, 2..256
- SEL_W, $clog2(N), select width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the beat this cycle
- s  input  SEL_W  channel select, sampled with the beat
- d  input  N*WIDTH  flattened channels; channel i = d[i*WIDTH +: WIDTH]
- out_valid  output  1  y holds a result
- out_ready  input  1  consumer accepts y this cycle
- y  output  WIDTH  selected channel

## Operation
- A beat transfers into the block when in_valid && in_ready. It transfers out when out_valid && out_ready.
- The tree has L = SEL_W levels.
  - Level k (k = 0..L-1) has N/2^(k+1) 2:1 muxes, each steered by select bit s[k], LSB first.
  - Level 0 pairs channel 2j with channel 2j+1. Select 0 picks the even input.
- Each level is one pipeline stage. A stage holds its data, its remaining select bits s[L-1:k+1], and a valid bit v_k.
- Result: y = channel s of the accepted beat. Beats leave in acceptance order.
- Stage k loads when !v_k || advance_(k+1). advance_L = out_ready.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- in_ready = !v_0 || (stage 1 will load this cycle). This is combinational from the valid bits and out_ready. There is no combinational path from in_valid, s or d.
- out_valid = v_(L-1). y = stage L-1 data.
- While out_valid && !out_ready, y and out_valid stay stable until accepted.
- N = 2 degenerates to a single registered stage. That case is legal and must work.

## Timing
- Latency: L cycles from acceptance to out_valid, with no stall. L = 3 for N = 8.
- Throughput: 1 beat/cycle when out_ready is held high.
- Capacity: L beats in flight.
- Reset values: out_valid = 0, y = 0, all v_k = 0, all data and select registers = 0.
- in_ready is 0 during the reset cycle and 1 from the first cycle after rst deasserts.
- Reset mid-operation: all in-flight beats are discarded and no partial result appears. Upstream must re-send.
- Simultaneous accept and emit when full: allowed. The pipeline shifts and stays full.
- in_valid with in_ready = 0: the beat is not taken. The source must hold s and d stable.
- s and d are don't-care while in_valid = 0. Registers may load them, but the valid bits stay 0.

## Structure
- Shared package mux_pkg holds:
  - default constants MUX_WIDTH_DEF = 3 and MUX_N_DEF = 8
  - the clog2 helper for Verilog-2001 flows
  - the channel-index macro for flattened buses
- Sub-module mux_tree_stage is one level.
  - Parameters: WIDTH and N_IN.
  - Contents: N_IN/2 instances of the existing mux_2_1, plus the stage data, select and valid registers, plus the load logic.
- mux_tree_pipe is a generate loop of L mux_tree_stage instances plus the in_ready/out_valid wiring. There is no other logic.

## Test plan
- Reset/idle (N=8, WIDTH=3): hold rst 2 cycles.
  - During reset: out_valid = 0, y = 0, in_ready = 0.
  - First cycle after rst falls: in_ready = 1.
- Full sweep: d = {7,6,5,4,3,2,1,0} (channel i = i), s = 0..7 on back-to-back cycles, out_ready = 1.
  - y = 0..7 on consecutive cycles, starting 3 cycles after the first accept.
- Backpressure: stream s = 5,2,7,1 with out_ready = 0 for 6 cycles.
  - out_valid rises after 3 cycles and y = 5 holds stable.
  - in_ready drops once 3 beats are held.
  - After out_ready rises, the outputs are 5,2,7,1 with no loss or duplication.
- Bubble collapse: accept one beat, stall the output, then idle in_valid for 2 cycles, then send a second beat.
  - The second beat is accepted while stalled.
  - The outputs are adjacent once out_ready = 1.
- Reset mid-stream: assert rst while 3 beats are in flight.
  - Next cycle: out_valid = 0.
  - No stale value ever appears after reset.
- Parameter sweep: N = 2, WIDTH = 1 and N = 32, WIDTH = 16, with random s, d and out_ready.
  - The scoreboard matches y = d[s] in order.
  - Latency equals $clog2(N) whenever the output is not stalled.
